// File: rtl/ifetch_align.sv
// Aligns 16/32-bit instructions out of 64-bit fetch lines; zero latency, split 32-bit words take one extra line.
// Latency: combinational from line/pc to instruction; a line-crossing 32-bit instruction completes when the next line lands.
// Backpressure: fet_stall freezes all state (outputs still follow inputs); redirect overrides stall. Macro RV16_EN enables compressed support.
module ifetch_align #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        isram_cs_ff,
    input  logic [63:0] isram_rdata,
    input  logic [31:0] pc,
    input  logic        fet_stall,
    input  logic        redirect,
    output logic [31:0] rv32_instr,
    output logic        isrv16,
    output logic        instr_valid,
    output logic        fetch_misalign,
    output logic        instr_addr_err
);

    logic [63:0] line_q, line_d;
    logic        line_vld_q, line_vld_d;
    logic [63:0] cur_line;
    logic        have_line;

    logic        vld;
    logic [31:0] instr_raw;
    logic        rv16_raw;

    // Upper pc bits select the line in the fetch unit, never here.
    logic unused_pc;
    assign unused_pc = ^{pc[31:3], pc[0]};

    always_comb begin
        cur_line   = isram_cs_ff ? isram_rdata : line_q;
        have_line  = isram_cs_ff | line_vld_q;
        line_d     = line_q;
        line_vld_d = line_vld_q;
        if (isram_cs_ff && !fet_stall) begin
            line_d     = isram_rdata;
            line_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            line_q     <= '0;
            line_vld_q <= 1'b0;
        end else begin
            line_q     <= line_d;
            line_vld_q <= line_vld_d;
        end
    end

`ifdef RV16_EN
    typedef enum logic {RUN, SPLIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] low, high;
    logic [1:0]  nxt_hw;
    logic        is32;
    logic        at_edge;

    always_comb begin
        nxt_hw  = pc[2:1] + 2'd1;
        low     = cur_line[{pc[2:1], 4'b0000} +: 16];
        high    = cur_line[{nxt_hw, 4'b0000} +: 16];
        is32    = (low[1:0] == 2'b11);
        at_edge = (pc[2:1] == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state_q <= RUN;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        if (redirect) begin
            state_d = RUN;
            hi_d    = '0;
        end else if (!fet_stall) begin
            case (state_q)
                RUN: begin
                    if (have_line && at_edge && is32) begin
                        state_d = SPLIT;
                        hi_d    = low;
                    end
                end
                SPLIT: begin
                    if (isram_cs_ff) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        vld            = 1'b0;
        instr_raw      = NOP_INSTR;
        rv16_raw       = 1'b0;
        fetch_misalign = 1'b0;
        instr_addr_err = 1'b0;
        if (!cpurst && !redirect) begin
            case (state_q)
                RUN: begin
                    if (have_line) begin
                        if (at_edge && is32) begin
                            fetch_misalign = 1'b1;
                        end else begin
                            vld       = 1'b1;
                            instr_raw = is32 ? {high, low} : {16'h0000, low};
                            rv16_raw  = ~is32;
                        end
                    end
                end
                SPLIT: begin
                    // The low half of the new line completes the held upper-line half.
                    if (isram_cs_ff) begin
                        vld       = 1'b1;
                        instr_raw = {isram_rdata[15:0], hi_q};
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_comb begin
        vld            = 1'b0;
        instr_raw      = NOP_INSTR;
        rv16_raw       = 1'b0;
        fetch_misalign = 1'b0;
        instr_addr_err = 1'b0;
        if (!cpurst) begin
            if (pc[1]) begin
                instr_addr_err = 1'b1;
            end else if (!redirect && have_line) begin
                vld       = 1'b1;
                instr_raw = pc[2] ? cur_line[63:32] : cur_line[31:0];
            end
        end
    end
`endif

    assign instr_valid = vld;
    assign rv32_instr  = vld ? instr_raw : NOP_INSTR;
    assign isrv16      = vld & rv16_raw;

endmodule

// File: tb/tb_ifetch_align.sv
// Scoreboarded bench for ifetch_align: expectations queued at drive time, compared on the falling edge.
module tb_ifetch_align;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        isram_cs_ff;
    logic [63:0] isram_rdata;
    logic [31:0] pc;
    logic        fet_stall;
    logic        redirect;
    logic [31:0] rv32_instr;
    logic        isrv16;
    logic        instr_valid;
    logic        fetch_misalign;
    logic        instr_addr_err;

    typedef struct {
        string       tag;
        logic        vld;
        logic [31:0] ins;
        logic        rv16;
        logic        mis;
        logic        aerr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ifetch_align #(.NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .cpurst         (cpurst),
        .isram_cs_ff    (isram_cs_ff),
        .isram_rdata    (isram_rdata),
        .pc             (pc),
        .fet_stall      (fet_stall),
        .redirect       (redirect),
        .rv32_instr     (rv32_instr),
        .isrv16         (isrv16),
        .instr_valid    (instr_valid),
        .fetch_misalign (fetch_misalign),
        .instr_addr_err (instr_addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic cs, input logic [63:0] rd,
                         input logic [31:0] p, input logic stl, input logic rdr);
        cpurst      = rst;
        isram_cs_ff = cs;
        isram_rdata = rd;
        pc          = p;
        fet_stall   = stl;
        redirect    = rdr;
    endtask

    task automatic push(input string tag, input logic v, input logic [31:0] ins,
                        input logic r16, input logic mis, input logic aerr);
        exp_t e;
        e.tag = tag; e.vld = v; e.ins = ins; e.rv16 = r16; e.mis = mis; e.aerr = aerr;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push(tag, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_ok(input string tag, input logic [31:0] ins, input logic r16);
        push(tag, 1'b1, ins, r16, 1'b0, 1'b0);
    endtask

    // Compare the pending expectation against the settled outputs, then advance one cycle.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".vld"},  {31'h0, instr_valid},    {31'h0, e.vld});
            chk({e.tag, ".ins"},  rv32_instr,              e.ins);
            chk({e.tag, ".rv16"}, {31'h0, isrv16},         {31'h0, e.rv16});
            chk({e.tag, ".mis"},  {31'h0, fetch_misalign}, {31'h0, e.mis});
            chk({e.tag, ".aerr"}, {31'h0, instr_addr_err}, {31'h0, e.aerr});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        push_idle("rst0");                               step();
        drive(1'b1, 1'b1, 64'h00A00093_00000013, 32'h0, 1'b0, 1'b0);
        push_idle("rst_with_line");                      step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_idle("no_line");                            step();

        drive(1'b0, 1'b1, 64'h00A00093_00000013, 32'h0, 1'b0, 1'b0);
        push_ok("first_word", 32'h0000_0013, 1'b0);      step();
        drive(1'b0, 1'b0, 64'h0, 32'h4, 1'b0, 1'b0);
        push_ok("held_word1", 32'h00A0_0093, 1'b0);      step();

        // Stalled line is visible but must not overwrite the held line.
        drive(1'b0, 1'b1, 64'h1111_2223_3333_4447, 32'h0, 1'b1, 1'b0);
`ifdef RV16_EN
        push_ok("stall_line", 32'h3333_4447, 1'b0);      step();
`else
        push_ok("stall_line", 32'h3333_4447, 1'b0);      step();
`endif
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_ok("line_kept", 32'h0000_0013, 1'b0);       step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        push_idle("redirect_kill");                      step();

`ifdef RV16_EN
        drive(1'b0, 1'b1, 64'h4501_0505_0513_0001, 32'h0, 1'b0, 1'b0);
        push_ok("c_hw0", 32'h0000_0001, 1'b1);           step();
        drive(1'b0, 1'b0, 64'h0, 32'h2, 1'b0, 1'b0);
        push_ok("w_hw1", 32'h0505_0513, 1'b0);           step();
        drive(1'b0, 1'b0, 64'h0, 32'h4, 1'b0, 1'b0);
        push_ok("c_hw2", 32'h0000_0505, 1'b1);           step();
        drive(1'b0, 1'b0, 64'h0, 32'h6, 1'b0, 1'b0);
        push_ok("c_edge", 32'h0000_4501, 1'b1);          step();

        // Line-crossing 32-bit instruction joined with the next line.
        drive(1'b0, 1'b1, 64'h0093_0000_0000_0000, 32'h6, 1'b0, 1'b0);
        push("split_a", 1'b0, NOP, 1'b0, 1'b1, 1'b0);    step();
        drive(1'b0, 1'b1, 64'h0000_0000_0001_00A0, 32'h6, 1'b0, 1'b0);
        push_ok("split_join", 32'h00A0_0093, 1'b0);      step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_ok("after_join", 32'h0000_00A0, 1'b1);      step();

        drive(1'b0, 1'b1, 64'h0093_0000_0000_0000, 32'h6, 1'b0, 1'b0);
        push("split_b", 1'b0, NOP, 1'b0, 1'b1, 1'b0);    step();
        drive(1'b0, 1'b1, 64'h0000_0000_0001_00A0, 32'h0, 1'b0, 1'b1);
        push_idle("split_redirect");                     step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_ok("after_redirect", 32'h0000_00A0, 1'b1);  step();

        drive(1'b0, 1'b1, 64'h1117_0000_0000_0000, 32'h6, 1'b0, 1'b0);
        push("split_c", 1'b0, NOP, 1'b0, 1'b1, 1'b0);    step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 64'h0, 32'h6, 1'b1, 1'b0);
            push_idle($sformatf("split_stall%0d", i));   step();
        end
        drive(1'b0, 1'b1, 64'h0000_0000_0000_2345, 32'h6, 1'b0, 1'b0);
        push_ok("stall_join", 32'h2345_1117, 1'b0);      step();

        drive(1'b0, 1'b1, 64'h0093_0000_0000_0000, 32'h6, 1'b0, 1'b0);
        push("split_d", 1'b0, NOP, 1'b0, 1'b1, 1'b0);    step();
        drive(1'b1, 1'b1, 64'h0000_0000_0000_0001, 32'h0, 1'b0, 1'b0);
        push_idle("split_reset");                        step();
        drive(1'b0, 1'b1, 64'h0000_0000_0000_0001, 32'h0, 1'b0, 1'b0);
        push_ok("after_reset", 32'h0000_0001, 1'b1);     step();
`else
        drive(1'b0, 1'b1, 64'hCAFE_0003_1234_5677, 32'h2, 1'b0, 1'b0);
        push("aerr_pc2", 1'b0, NOP, 1'b0, 1'b0, 1'b1);   step();
        drive(1'b0, 1'b0, 64'h0, 32'h6, 1'b0, 1'b0);
        push("aerr_pc6", 1'b0, NOP, 1'b0, 1'b0, 1'b1);   step();
        drive(1'b0, 1'b0, 64'h0, 32'h4, 1'b0, 1'b0);
        push_ok("word1", 32'hCAFE_0003, 1'b0);           step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_ok("word0", 32'h1234_5677, 1'b0);           step();
        drive(1'b1, 1'b0, 64'h0, 32'h2, 1'b0, 1'b0);
        push_idle("rst_pc2");                            step();
        drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        push_idle("rst_cleared_line");                   step();
`endif

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
